lstm_event_fifo: RTL

//  Upstream feeder of the softmax anomaly stage: buffers decoded trace events {type, index}
//  in a DEPTH-entry circular FIFO and issues them as single-cycle oFIFO_valid/oFIFO_data pulses.
//  The softmax stage has no ready, so this block paces issue by type-specific gaps.

---
 rtl/lstm_event_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lstm_event_fifo.sv
// Trace-event FIFO feeding the softmax anomaly stage; issue is paced by per-type gaps.
// Optional dropped-push counter enabled by defining LSTM_EVT_FIFO_DROP_CNT_EN.
module lstm_event_fifo #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int SYS_GAP = 14,
    parameter int BR_GAP  = 70
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iEvt_valid,
    input  logic              iEvt_type,
    input  logic [11:0]       iEvt_id,
    input  logic              iFlush,
    output logic              oFIFO_valid,
    output logic [12:0]       oFIFO_data,
    output logic              oFull,
    output logic              oEmpty,
    output logic [ADDR_W:0]   oCount,
    output logic              oOverflow,
    output logic [15:0]       oDrop_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      SYS_GAP_M1 = 8'(SYS_GAP - 1);
    localparam logic [7:0]      BR_GAP_M1  = 8'(BR_GAP - 1);

    logic [12:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    state_e            state_q, state_d;
    logic [7:0]        gap_q, gap_d;
    logic              valid_q, valid_d;
    logic [12:0]       data_q, data_d;
    logic              ovf_q, ovf_d;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [12:0]       wdata;
    logic [12:0]       head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // SYS events only carry an 8-bit index; upper nibble is cleared on entry
    assign wdata = {iEvt_type,
                    iEvt_type ? {4'h0, iEvt_id[7:0]} : iEvt_id};

    // Issue FSM: gap reaching zero in HOLD behaves like IDLE
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        valid_d = 1'b0;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            ST_HOLD: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            valid_d = 1'b1;
            data_d  = head;
            gap_d   = head[12] ? SYS_GAP_M1 : BR_GAP_M1;
            state_d = ST_HOLD;
        end
        if (iFlush) begin
            state_d = ST_IDLE;
            gap_d   = 8'd0;
            valid_d = 1'b0;
            data_d  = data_q;
            pop     = 1'b0;
        end
    end

    // Occupancy bookkeeping; a pop frees a slot for a same-cycle push
    always_comb begin
        push_ok  = iEvt_valid && !iFlush && (!full || pop);
        drop     = iEvt_valid && !iFlush && !push_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (iFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            gap_q    <= 8'd0;
            valid_q  <= 1'b0;
            data_q   <= 13'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef LSTM_EVT_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating; flush leaves it alone so only reset clears it
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign oDrop_cnt = drop_cnt_q;
`else
    assign oDrop_cnt = 16'd0;
`endif

    assign oFIFO_valid = valid_q;
    assign oFIFO_data  = data_q;
    assign oFull       = full;
    assign oEmpty      = empty;
    assign oCount      = count_q;
    assign oOverflow   = ovf_q;

endmodule
